// File: rtl/imme_ext_pipe.sv
// -----------------------------------------------------------------------------
// imme_ext_pipe
//
// Immediate extension unit for the MIPS decode stage. Each accepted immediate
// is extended to DATA_SIZE bits using one of four rules, selected by i_mode:
//   00 sign   : replicate the immediate MSB into the upper bits
//   01 zero   : fill the upper bits with zeros
//   10 upper  : {imme, zeros}  (LUI form)
//   11 branch : sign-extend, then shift left by 2 (word offset)
// The extended value and its sideband tag are stored in a 2-entry FIFO. The
// head entry drives e_imme/o_tag and the skid entry absorbs one extra entry
// when the consumer stalls. Because extension happens before storage, the
// output path is a plain register.
//
// Configuration macro: IMME_EXT_BRANCH_EN
//   defined     : mode 11 applies the branch-offset rule (sign-extend, << 2)
//   not defined : no shifter is built and mode 11 behaves exactly as mode 00
//
// Parameters:
//   IMME_SIZE  raw immediate width (2 <= IMME_SIZE < DATA_SIZE)
//   DATA_SIZE  extended output width
//   TAG_SIZE   sideband tag width (>= 1), passed through unchanged
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   flush    synchronous squash of all buffered entries (beats accept/pop)
//   i_valid  input entry present
//   i_ready  unit can accept (registered)
//   i_imme   raw immediate
//   i_mode   extension rule select
//   i_tag    sideband tag
//   o_valid  head entry present
//   o_ready  consumer accepts the head entry
//   e_imme   extended immediate of the head entry
//   o_tag    tag of the head entry
//   o_count  number of buffered entries, 0..2
// -----------------------------------------------------------------------------
module imme_ext_pipe #(
  parameter int IMME_SIZE = 16,
  parameter int DATA_SIZE = 32,
  parameter int TAG_SIZE  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [IMME_SIZE-1:0] i_imme,
  input  logic [1:0]           i_mode,
  input  logic [TAG_SIZE-1:0]  i_tag,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [DATA_SIZE-1:0] e_imme,
  output logic [TAG_SIZE-1:0]  o_tag,
  output logic [1:0]           o_count
);

  localparam int EXT_SIZE = DATA_SIZE - IMME_SIZE;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Extension, evaluated on the input side so stored entries are final values.
  // ---------------------------------------------------------------------------
  logic [DATA_SIZE-1:0] sext;
  logic [DATA_SIZE-1:0] ext;

  assign sext = {{EXT_SIZE{i_imme[IMME_SIZE-1]}}, i_imme};

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    ext = sext;
    case (mode_e'(i_mode))
      MODE_SIGN:   ext = sext;
      MODE_ZERO:   ext = {{EXT_SIZE{1'b0}}, i_imme};
      MODE_UPPER:  ext = {i_imme, {EXT_SIZE{1'b0}}};
`ifdef IMME_EXT_BRANCH_EN
      // Bits shifted past the top are discarded; low two bits become zero.
      MODE_BRANCH: ext = {sext[DATA_SIZE-3:0], 2'b00};
`else
      MODE_BRANCH: ext = sext;
`endif
      default:     ext = sext;
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-entry FIFO: head (drives outputs) and skid (second entry).
  // ---------------------------------------------------------------------------
  logic [DATA_SIZE-1:0] head_data, skid_data;
  logic [TAG_SIZE-1:0]  head_tag,  skid_tag;
  logic [1:0]           count_q, count_next;
  logic                 ready_q;
  logic                 push, pop;

  assign push = i_valid && ready_q;
  assign pop  = (count_q != 2'd0) && o_ready;

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;  // idle, or accept+pop: occupancy unchanged
    endcase
    if (flush) count_next = 2'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      count_q <= count_next;
      // i_ready is a register loaded from the next occupancy, so it never
      // depends combinationally on o_ready.
      ready_q <= (count_next < 2'd2);
    end
  end

  // NOTE: the two data registers are reset because e_imme/o_tag must read
  // zero out of reset; flush leaves them alone since o_valid masks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data <= '0;
      head_tag  <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      if (pop) begin
        if (count_q == 2'd2) begin
          // Skid moves up; no accept is possible while full.
          head_data <= skid_data;
          head_tag  <= skid_tag;
        end else if (push) begin
          // Single entry popped and replaced in the same cycle.
          head_data <= ext;
          head_tag  <= i_tag;
        end
      end else if (push) begin
        if (count_q == 2'd0) begin
          head_data <= ext;
          head_tag  <= i_tag;
        end else begin
          skid_data <= ext;
          skid_tag  <= i_tag;
        end
      end
    end
  end

  assign i_ready = ready_q;
  assign o_valid = (count_q != 2'd0);
  assign o_count = count_q;
  assign e_imme  = head_data;
  assign o_tag   = head_tag;

endmodule

// File: tb/tb_imme_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_imme_ext_pipe
//
// Directed bench for imme_ext_pipe (16 -> 32, 5-bit tag). Inputs change 1 ns
// after each rising edge and outputs are sampled at the same point, so every
// sample reflects the state loaded by the preceding edge.
// Expected values for mode 11 follow the IMME_EXT_BRANCH_EN setting of the
// build.
// -----------------------------------------------------------------------------
module tb_imme_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_imme;
  logic [1:0]  i_mode;
  logic [4:0]  i_tag;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] e_imme;
  logic [4:0]  o_tag;
  logic [1:0]  o_count;

  int n_cmp = 0;
  int n_err = 0;

  imme_ext_pipe #(
    .IMME_SIZE(16),
    .DATA_SIZE(32),
    .TAG_SIZE (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_imme (i_imme),
    .i_mode (i_mode),
    .i_tag  (i_tag),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .e_imme (e_imme),
    .o_tag  (o_tag),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] imme, input logic [1:0] mode, input logic [4:0] tag);
    i_valid = 1'b1;
    i_imme  = imme;
    i_mode  = mode;
    i_tag   = tag;
  endtask

  // status = {o_valid, i_ready, o_count}
  task automatic test_reset();
    if ({o_valid, i_ready, o_count} !== 4'b0100) begin
      $display("FAIL reset_status got %b exp %b", {o_valid, i_ready, o_count}, 4'b0100); n_err++;
    end
    n_cmp++;
    if (e_imme !== 32'h0) begin
      $display("FAIL reset_e_imme got %h exp %h", e_imme, 32'h0); n_err++;
    end
    n_cmp++;
    if (o_tag !== 5'd0) begin
      $display("FAIL reset_o_tag got %0d exp %0d", o_tag, 0); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_modes();
    logic [15:0] imme [6];
    logic [1:0]  mode [6];
    logic [31:0] expv [6];
    imme[0] = 16'h8001; mode[0] = 2'b00; expv[0] = 32'hFFFF8001;
    imme[1] = 16'h8001; mode[1] = 2'b01; expv[1] = 32'h00008001;
    imme[2] = 16'h1234; mode[2] = 2'b10; expv[2] = 32'h12340000;
    imme[3] = 16'h7FFF; mode[3] = 2'b00; expv[3] = 32'h00007FFF;
`ifdef IMME_EXT_BRANCH_EN
    imme[4] = 16'hFFFF; mode[4] = 2'b11; expv[4] = 32'hFFFFFFFC;
    imme[5] = 16'h0004; mode[5] = 2'b11; expv[5] = 32'h00000010;
`else
    imme[4] = 16'hFFFF; mode[4] = 2'b11; expv[4] = 32'hFFFFFFFF;
    imme[5] = 16'h0004; mode[5] = 2'b11; expv[5] = 32'h00000004;
`endif
    o_ready = 1'b1;
    // Back-to-back offers: each result appears exactly one edge after accept.
    for (int i = 0; i < 6; i++) begin
      offer(imme[i], mode[i], 5'(i + 1));
      step();
      if ({o_valid, o_count} !== 3'b101) begin
        $display("FAIL mode%0d_status got %b exp %b", i, {o_valid, o_count}, 3'b101); n_err++;
      end
      n_cmp++;
      if (e_imme !== expv[i]) begin
        $display("FAIL mode%0d_e_imme got %h exp %h", i, e_imme, expv[i]); n_err++;
      end
      n_cmp++;
      if (o_tag !== 5'(i + 1)) begin
        $display("FAIL mode%0d_tag got %0d exp %0d", i, o_tag, i + 1); n_err++;
      end
      n_cmp++;
    end
    i_valid = 1'b0;
    step();
    if ({o_valid, i_ready, o_count} !== 4'b0100) begin
      $display("FAIL mode_drain got %b exp %b", {o_valid, i_ready, o_count}, 4'b0100); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    o_ready = 1'b0;
    offer(16'd1, 2'b01, 5'd1);
    step();
    if ({o_valid, i_ready, o_count} !== 4'b1101) begin
      $display("FAIL bp_first got %b exp %b", {o_valid, i_ready, o_count}, 4'b1101); n_err++;
    end
    n_cmp++;
    offer(16'd2, 2'b01, 5'd2);
    step();
    if ({o_valid, i_ready, o_count} !== 4'b1010) begin
      $display("FAIL bp_full got %b exp %b", {o_valid, i_ready, o_count}, 4'b1010); n_err++;
    end
    n_cmp++;
    offer(16'd3, 2'b01, 5'd3);
    step();
    // Tag 3 held off; head stays on tag 1 while stalled.
    if ({o_valid, i_ready, o_count, o_tag, e_imme} !== {4'b1010, 5'd1, 32'd1}) begin
      $display("FAIL bp_hold got %b/%0d/%h exp 1010/1/00000001",
               {o_valid, i_ready, o_count}, o_tag, e_imme); n_err++;
    end
    n_cmp++;
    o_ready = 1'b1;
    step();
    if ({o_valid, i_ready, o_count, o_tag} !== {4'b1101, 5'd2}) begin
      $display("FAIL bp_pop1 got %b/%0d exp 1101/2", {o_valid, i_ready, o_count}, o_tag); n_err++;
    end
    n_cmp++;
    step();
    if ({o_valid, o_count, o_tag, e_imme} !== {3'b101, 5'd3, 32'd3}) begin
      $display("FAIL bp_pop2 got %b/%0d/%h exp 101/3/00000003", {o_valid, o_count}, o_tag, e_imme); n_err++;
    end
    n_cmp++;
    i_valid = 1'b0;
    step();
    if ({o_valid, i_ready, o_count} !== 4'b0100) begin
      $display("FAIL bp_empty got %b exp %b", {o_valid, i_ready, o_count}, 4'b0100); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b0;
    offer(16'd10, 2'b00, 5'd10);
    step();
    o_ready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      offer(16'(k), 2'b00, 5'(k));
      step();
      if ({o_valid, i_ready, o_count, o_tag} !== {4'b1101, 5'(k)}) begin
        $display("FAIL b2b_%0d got %b/%0d exp 1101/%0d", k, {o_valid, i_ready, o_count}, o_tag, k); n_err++;
      end
      n_cmp++;
      if (e_imme !== 32'(k)) begin
        $display("FAIL b2b_%0d_e_imme got %h exp %h", k, e_imme, 32'(k)); n_err++;
      end
      n_cmp++;
    end
    i_valid = 1'b0;
    step();
    if (o_count !== 2'd0) begin
      $display("FAIL b2b_drain got %0d exp 0", o_count); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_flush();
    o_ready = 1'b0;
    offer(16'd20, 2'b00, 5'd20);
    step();
    offer(16'd21, 2'b00, 5'd21);
    step();
    offer(16'd22, 2'b00, 5'd22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    i_valid = 1'b0;
    if ({o_valid, i_ready, o_count} !== 4'b0100) begin
      $display("FAIL flush_full got %b exp %b", {o_valid, i_ready, o_count}, 4'b0100); n_err++;
    end
    n_cmp++;
    step();
    if ({o_valid, o_count} !== 3'b000) begin
      $display("FAIL flush_stays_empty got %b exp %b", {o_valid, o_count}, 3'b000); n_err++;
    end
    n_cmp++;
    // Flush at count 1 with an accept and a pop in the same cycle.
    offer(16'd23, 2'b00, 5'd23);
    step();
    o_ready = 1'b1;
    offer(16'd24, 2'b00, 5'd24);
    flush = 1'b1;
    step();
    flush = 1'b0;
    i_valid = 1'b0;
    if ({o_valid, i_ready, o_count} !== 4'b0100) begin
      $display("FAIL flush_accept got %b exp %b", {o_valid, i_ready, o_count}, 4'b0100); n_err++;
    end
    n_cmp++;
    // A fresh entry after flush must be the only one seen.
    offer(16'd25, 2'b00, 5'd25);
    step();
    i_valid = 1'b0;
    if ({o_valid, o_count, o_tag} !== {3'b101, 5'd25}) begin
      $display("FAIL flush_next got %b/%0d exp 101/25", {o_valid, o_count}, o_tag); n_err++;
    end
    n_cmp++;
    step();
  endtask

  task automatic test_async_reset();
    o_ready = 1'b0;
    offer(16'h0030, 2'b00, 5'd30);
    step();
    offer(16'h0031, 2'b00, 5'd31);
    step();
    i_valid = 1'b0;
    if (o_count !== 2'd2) begin
      $display("FAIL areset_setup got %0d exp 2", o_count); n_err++;
    end
    n_cmp++;
    #2 rst = 1'b1;
    #1;
    if ({o_valid, i_ready, o_count, o_tag, e_imme} !== {4'b0100, 5'd0, 32'd0}) begin
      $display("FAIL areset_immediate got %b/%0d/%h exp 0100/0/00000000",
               {o_valid, i_ready, o_count}, o_tag, e_imme); n_err++;
    end
    n_cmp++;
    #1 rst = 1'b0;
    offer(16'h0032, 2'b01, 5'd9);
    step();
    i_valid = 1'b0;
    if ({o_valid, o_count, o_tag, e_imme} !== {3'b101, 5'd9, 32'h32}) begin
      $display("FAIL areset_first_accept got %b/%0d/%h exp 101/9/00000032",
               {o_valid, o_count}, o_tag, e_imme); n_err++;
    end
    n_cmp++;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    i_valid = 1'b0;
    i_imme  = '0;
    i_mode  = '0;
    i_tag   = '0;
    o_ready = 1'b0;
    step();
    test_reset();
    step();
    #3 rst = 1'b0;
    step();
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imme_ext_pipe.md
# imme_ext_pipe

Parametrised, mode-selectable immediate extension unit with a registered valid/ready output and a 2-entry skid buffer, for the decode stage of the pipelined MIPS core. Each accepted instruction immediate is extended to the datapath width by sign, zero, upper-half or branch-offset rule, then held until the execute stage takes it. An optional tag travels with each entry, for example a destination register index. Stall is by backpressure and flush is synchronous, so decode can be frozen or squashed without losing order.

## Interface
Parameters:
- IMME_SIZE, 16, immediate width; legal range 2 ≤ IMME_SIZE < DATA_SIZE
- DATA_SIZE, 32, extended output width
- TAG_SIZE, 5, sideband tag width (≥1), passed through unchanged

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous squash of all buffered entries
- i_valid  input  1  input entry present
- i_ready  output  1  unit can accept; registered
- i_imme  input  IMME_SIZE  raw immediate
- i_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch
- i_tag  input  TAG_SIZE  sideband tag
- o_valid  output  1  output entry present
- o_ready  input  1  consumer accepts
- e_imme  output  DATA_SIZE  extended immediate of head entry
- o_tag  output  TAG_SIZE  tag of head entry
- o_count  output  2  buffered entries, 0..2

## Operation
- Extension is computed at accept time and stored; no extension logic sits on the output path.
- Sign (00): i_imme replicated MSB into upper DATA_SIZE−IMME_SIZE bits.
- Zero (01): upper bits zero.
- Upper (10): {i_imme, (DATA_SIZE−IMME_SIZE) zeros}, i.e. the LUI form; uses only the low DATA_SIZE bits, no overflow.
- Branch (11): sign-extend, then shift left 2; low 2 bits 0, bits shifted past DATA_SIZE−1 are discarded.
- Storage is a 2-entry FIFO: head register drives e_imme/o_tag, skid register catches one entry when o_ready falls.
- Accept when i_valid && i_ready; pop when o_valid && o_ready.
- Accept and pop in the same cycle: count unchanged, order preserved.
- o_valid = (count ≠ 0). i_ready = (count < 2), registered from next-state count.
- Accept while full cannot occur because i_ready is 0. Pop while empty is ignored.
- flush: next cycle count = 0, o_valid = 0, i_ready = 1. Flush overrides any simultaneous accept and pop; that input entry is dropped.
- Data/tag registers need not be cleared by flush; they are don't-care while o_valid = 0.

## Timing
- Reset values: o_valid 0, i_ready 1, e_imme 0, o_tag 0, o_count 0; reset is effective immediately and asynchronously.
- Reset mid-operation discards all entries. First accept is possible on the first rising edge after rst deasserts.
- Latency is 1 cycle: an entry accepted at edge N appears on e_imme with o_valid = 1 after edge N.
- Throughput is 1 entry/cycle while o_ready stays high.
- o_ready low with empty unit: up to two accepts, then i_ready = 0 the cycle after the second accept.
- After o_ready rises with count = 2, i_ready returns to 1 the cycle after the first pop.
- Outputs hold stable while o_valid && !o_ready.

## Configuration
- IMME_EXT_BRANCH_EN defined: mode 11 is the branch-offset rule described above.
- Not defined: the branch shifter is not built and mode 11 behaves exactly as mode 00, sign-extend with no shift.
- Modes 00/01/10 are unaffected either way.

## Test plan
- Modes (16→32, o_ready = 1): 0x8001/00 → 0xFFFF8001; 0x8001/01 → 0x00008001; 0x1234/10 → 0x12340000; 0xFFFF/11 → 0xFFFFFFFC; each 1 cycle after accept, tags echoed.
- Backpressure: hold o_ready = 0 and offer tags 1, 2, 3 back-to-back. Expect tags 1 and 2 accepted, i_ready = 0 and o_count = 2, tag 3 held off. Release o_ready and expect outputs in order 1, 2, 3 with no gaps or duplicates.
- Simultaneous accept and pop at count = 1 for 4 cycles: o_count stays 1 and each output follows its input by exactly one cycle.
- Flush at count = 2 with i_valid = 1 in the same cycle: next cycle o_valid = 0, o_count = 0, i_ready = 1, and the flushed-cycle input never appears.
- Assert rst asynchronously between edges with count = 2: all outputs take their reset values immediately, and an accept on the first edge after release gives o_count = 1.
- Build without IMME_EXT_BRANCH_EN: 0x0004/11 → 0x00000004 and 0xFFFF/11 → 0xFFFFFFFF.
